nf10_output_distributor: RTL and testbench

Packet distributor: one AXI4-Stream slave input to three AXI4-Stream master outputs, steered per packet by the one-hot destination field of the first word's tuser. It sits at the egress end of the datapath, after the output-port lookup, and fans packets out to the per-port TX queues. Multicast is supported: a word is held until every selected output has accepted it.

---
 rtl/nf10_output_distributor_if.sv | 15 +
 rtl/nf10_output_distributor.sv | 156 +++++++++++++++
 tb/tb_nf10_output_distributor.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nf10_output_distributor_if.sv
// AXI4-Stream bundle used for the distributor's slave input and each of its master outputs.
interface nf10_output_distributor_if #(
    parameter int unsigned DataWidth  = 256,
    parameter int unsigned TuserWidth = 128
);
    logic [DataWidth-1:0]   tdata;
    logic [DataWidth/8-1:0] tstrb;
    logic [TuserWidth-1:0]  tuser;
    logic                   tvalid;
    logic                   tready;
    logic                   tlast;

    modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/nf10_output_distributor.sv
// One-to-three AXI4-Stream packet distributor with multicast, steered by the first word's tuser.
// Define NF10_OUTPUT_DISTRIBUTOR_DROP_EN to drop zero-destination packets instead of sending to port 0.
module nf10_output_distributor #(
    parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned NUM_QUEUES           = 3,
    parameter int unsigned C_DST_OFFSET         = 24
) (
    input  logic                             axi_aclk,
    input  logic                             axi_reset,
    nf10_output_distributor_if.slave         s_axis,
    nf10_output_distributor_if.master        m_axis_0,
    nf10_output_distributor_if.master        m_axis_1,
    nf10_output_distributor_if.master        m_axis_2
);
    localparam int unsigned DW = C_S_AXIS_DATA_WIDTH;
    localparam int unsigned UW = C_S_AXIS_TUSER_WIDTH;

    if (C_M_AXIS_DATA_WIDTH != C_S_AXIS_DATA_WIDTH ||
        C_M_AXIS_TUSER_WIDTH != C_S_AXIS_TUSER_WIDTH || NUM_QUEUES != 3) begin : g_bad_cfg
        $error("nf10_output_distributor: unsupported parameter set");
    end

`ifdef NF10_OUTPUT_DISTRIBUTOR_DROP_EN
    typedef enum logic [1:0] {StIdle, StPkt, StDrop} state_e;
`else
    typedef enum logic [0:0] {StIdle, StPkt} state_e;
`endif

    state_e          state_q, state_d;
    logic [DW-1:0]   data_q;
    logic [DW/8-1:0] strb_q;
    logic [UW-1:0]   user_q;
    logic            last_q;
    logic            hold_valid_q, hold_valid_d;
    logic [2:0]      pending_q, pending_d;
    logic [2:0]      dest_q, dest_d;

    logic [2:0]      m_tready, m_tvalid, out_accept;
    logic [2:0]      dst_field, dest_sel;
    logic            retire, in_drop, drop_word, s_tready, s_accept, load;

    assign m_tready   = {m_axis_2.tready, m_axis_1.tready, m_axis_0.tready};
    assign m_tvalid   = {3{hold_valid_q}} & pending_q;
    assign out_accept = m_tvalid & m_tready;
    // The held word retires once every output it still owes has accepted, possibly this cycle.
    assign retire     = hold_valid_q & ((pending_q & ~out_accept) == 3'b000);
    assign dst_field  = s_axis.tuser[C_DST_OFFSET +: NUM_QUEUES];

`ifdef NF10_OUTPUT_DISTRIBUTOR_DROP_EN
    assign in_drop = (state_q == StDrop);
`else
    assign in_drop = 1'b0;
`endif

    assign s_tready = ~axi_reset & (in_drop | ~hold_valid_q | retire);
    assign s_accept = s_axis.tvalid & s_tready;
    assign load     = s_accept & ~in_drop & ~drop_word;

    always_comb begin
        state_d   = state_q;
        dest_d    = dest_q;
        dest_sel  = dest_q;
        drop_word = 1'b0;
        unique case (state_q)
            StIdle: begin
                dest_sel = dst_field;
                if (dst_field == 3'b000) begin
`ifdef NF10_OUTPUT_DISTRIBUTOR_DROP_EN
                    drop_word = 1'b1;
`else
                    dest_sel  = 3'b001;
`endif
                end
                if (s_accept) begin
                    dest_d = dest_sel;
                    if (!s_axis.tlast) begin
`ifdef NF10_OUTPUT_DISTRIBUTOR_DROP_EN
                        state_d = drop_word ? StDrop : StPkt;
`else
                        state_d = StPkt;
`endif
                    end
                end
            end
            StPkt: begin
                if (s_accept && s_axis.tlast) state_d = StIdle;
            end
`ifdef NF10_OUTPUT_DISTRIBUTOR_DROP_EN
            StDrop: begin
                if (s_accept && s_axis.tlast) state_d = StIdle;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        hold_valid_d = hold_valid_q;
        pending_d    = pending_q & ~out_accept;
        if (retire) begin
            hold_valid_d = 1'b0;
            pending_d    = 3'b000;
        end
        if (load) begin
            hold_valid_d = 1'b1;
            pending_d    = dest_sel;
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state_q      <= StIdle;
            hold_valid_q <= 1'b0;
            pending_q    <= 3'b000;
            dest_q       <= 3'b000;
        end else begin
            state_q      <= state_d;
            hold_valid_q <= hold_valid_d;
            pending_q    <= pending_d;
            dest_q       <= dest_d;
        end
    end

    // Payload needs no reset: it is only observable while hold_valid_q is set.
    always_ff @(posedge axi_aclk) begin
        if (load) begin
            data_q <= s_axis.tdata;
            strb_q <= s_axis.tstrb;
            user_q <= s_axis.tuser;
            last_q <= s_axis.tlast;
        end
    end

    assign s_axis.tready = s_tready;

    assign m_axis_0.tdata  = data_q;
    assign m_axis_0.tstrb  = strb_q;
    assign m_axis_0.tuser  = user_q;
    assign m_axis_0.tlast  = last_q;
    assign m_axis_0.tvalid = m_tvalid[0];

    assign m_axis_1.tdata  = data_q;
    assign m_axis_1.tstrb  = strb_q;
    assign m_axis_1.tuser  = user_q;
    assign m_axis_1.tlast  = last_q;
    assign m_axis_1.tvalid = m_tvalid[1];

    assign m_axis_2.tdata  = data_q;
    assign m_axis_2.tstrb  = strb_q;
    assign m_axis_2.tuser  = user_q;
    assign m_axis_2.tlast  = last_q;
    assign m_axis_2.tvalid = m_tvalid[2];
endmodule

// File: tb/tb_nf10_output_distributor.sv
// Randomised bench for nf10_output_distributor against a packet-level routing model.
module tb_nf10_output_distributor;
    localparam int unsigned DW     = 256;
    localparam int unsigned SW     = DW / 8;
    localparam int unsigned UW     = 128;
    localparam int unsigned DstOff = 24;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic [UW-1:0] user;
        logic          last;
    } word_t;
    typedef logic [447:0] val_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nf10_output_distributor_if #(.DataWidth(DW), .TuserWidth(UW)) s_if ();
    nf10_output_distributor_if #(.DataWidth(DW), .TuserWidth(UW)) m0_if ();
    nf10_output_distributor_if #(.DataWidth(DW), .TuserWidth(UW)) m1_if ();
    nf10_output_distributor_if #(.DataWidth(DW), .TuserWidth(UW)) m2_if ();

    nf10_output_distributor dut (
        .axi_aclk  (clk),
        .axi_reset (rst),
        .s_axis    (s_if),
        .m_axis_0  (m0_if),
        .m_axis_1  (m1_if),
        .m_axis_2  (m2_if)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input val_t got, input val_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Stimulus and model state
    word_t       send_q[$];
    word_t       exp_q[3][$];
    bit          presented = 0;
    bit          rst_req = 1;
    int unsigned gap_pct = 0;
    int unsigned ready_pct[3] = '{100, 100, 100};
    int unsigned n_accept = 0;
    bit          model_first = 1;
    bit          model_drop = 0;
    logic [2:0]  model_dest = 3'b000;
    logic [2:0]  cur_v, cur_r, prev_v, prev_r;
    word_t       prev_w[3];
    bit          prev_rst = 1;

    function automatic word_t mk_word(input logic [2:0] dst, input bit last);
        word_t w;
        for (int i = 0; i < DW / 32; i++) w.data[i*32 +: 32] = $urandom();
        w.strb = $urandom();
        for (int i = 0; i < UW / 32; i++) w.user[i*32 +: 32] = $urandom();
        w.user[DstOff +: 3] = dst;
        w.last = last;
        return w;
    endfunction

    task automatic push_pkt(input logic [2:0] dst, input int len, input logic [2:0] later_dst);
        for (int i = 0; i < len; i++) send_q.push_back(mk_word(i == 0 ? dst : later_dst, i == len - 1));
    endtask

    // Routing rules applied to each accepted slave word, in packet terms.
    task automatic model_accept(input word_t x);
        logic [2:0] d;
        if (model_first) begin
            d = x.user[DstOff +: 3];
            if (d == 3'b000) begin
`ifdef NF10_OUTPUT_DISTRIBUTOR_DROP_EN
                model_drop = 1;
`else
                d = 3'b001;
`endif
            end
            model_dest = d;
        end else begin
            d = model_dest;
        end
        if (!model_drop)
            for (int k = 0; k < 3; k++) if (d[k]) exp_q[k].push_back(x);
        if (x.last) begin
            model_first = 1;
            model_drop  = 0;
        end else begin
            model_first = 0;
        end
    endtask

    task automatic observe();
        word_t w[3];
        cur_v = {m2_if.tvalid, m1_if.tvalid, m0_if.tvalid};
        cur_r = {m2_if.tready, m1_if.tready, m0_if.tready};
        w[0] = {m0_if.tdata, m0_if.tstrb, m0_if.tuser, m0_if.tlast};
        w[1] = {m1_if.tdata, m1_if.tstrb, m1_if.tuser, m1_if.tlast};
        w[2] = {m2_if.tdata, m2_if.tstrb, m2_if.tuser, m2_if.tlast};
        for (int k = 0; k < 3; k++) begin
            if (!prev_rst && prev_v[k] && !prev_r[k]) begin
                check_eq($sformatf("out%0d_tvalid_hold", k), val_t'(cur_v[k]), val_t'(1'b1));
                check_eq($sformatf("out%0d_payload_hold", k), val_t'(w[k]), val_t'(prev_w[k]));
            end
        end
        if (cur_v[0] && cur_v[1]) check_eq("payload_0_vs_1", val_t'(w[1]), val_t'(w[0]));
        if (cur_v[0] && cur_v[2]) check_eq("payload_0_vs_2", val_t'(w[2]), val_t'(w[0]));
        if (cur_v[1] && cur_v[2]) check_eq("payload_1_vs_2", val_t'(w[2]), val_t'(w[1]));
        if (rst) begin
            check_eq("s_tready_in_reset", val_t'(s_if.tready), val_t'(1'b0));
            for (int k = 0; k < 3; k++) exp_q[k].delete();
            model_first = 1;
            model_drop  = 0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (cur_v[k] && cur_r[k]) begin
                    if (exp_q[k].size() == 0)
                        check_eq($sformatf("out%0d_spurious", k), val_t'(cur_v[k]), val_t'(1'b0));
                    else
                        check_eq($sformatf("out%0d_word", k), val_t'(w[k]), val_t'(exp_q[k].pop_front()));
                end
            end
            if (s_if.tvalid && s_if.tready) begin
                model_accept(send_q.pop_front());
                presented = 0;
                n_accept++;
            end
        end
        prev_v   = cur_v;
        prev_r   = cur_r;
        prev_w   = w;
        prev_rst = rst;
    endtask

    task automatic step();
        @(negedge clk);
        rst = rst_req;
        if (!presented && send_q.size() > 0 && $urandom_range(99) >= gap_pct) presented = 1;
        s_if.tvalid = presented;
        if (presented) begin
            s_if.tdata = send_q[0].data;
            s_if.tstrb = send_q[0].strb;
            s_if.tuser = send_q[0].user;
            s_if.tlast = send_q[0].last;
        end
        m0_if.tready = ($urandom_range(99) < ready_pct[0]);
        m1_if.tready = ($urandom_range(99) < ready_pct[1]);
        m2_if.tready = ($urandom_range(99) < ready_pct[2]);
        #1;
        observe();
    endtask

    task automatic step_until_accepts(input int unsigned target, input string tag);
        int n = 0;
        while (n_accept < target && n < 200) begin
            step();
            n++;
        end
        check_eq({tag, "_accept_timeout"}, val_t'(n_accept >= target), val_t'(1'b1));
    endtask

    function automatic bit busy();
        return send_q.size() != 0 || presented ||
               exp_q[0].size() != 0 || exp_q[1].size() != 0 || exp_q[2].size() != 0;
    endfunction

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (busy() && n < budget) begin
            step();
            n++;
        end
        check_eq({tag, "_drain_timeout"}, val_t'(busy()), val_t'(1'b0));
    endtask

    initial begin
        int unsigned a0;
        s_if.tvalid = 0;
        s_if.tdata  = '0;
        s_if.tstrb  = '0;
        s_if.tuser  = '0;
        s_if.tlast  = 0;
        m0_if.tready = 0;
        m1_if.tready = 0;
        m2_if.tready = 0;
        prev_v = '0;
        prev_r = '0;

        // Reset state
        repeat (3) step();
        rst_req = 0;
        step();
        check_eq("reset_tvalid", val_t'(cur_v), val_t'(3'b000));
        check_eq("reset_s_tready", val_t'(s_if.tready), val_t'(1'b1));

        // Unicast to port 1: registered latency, four consecutive beats
        push_pkt(3'b010, 4, 3'b010);
        step_until_accepts(n_accept + 1, "t1");
        for (int j = 0; j < 4; j++) begin
            step();
            check_eq($sformatf("t1_tvalid_beat%0d", j), val_t'(cur_v), val_t'(3'b010));
        end
        step();
        check_eq("t1_idle_after", val_t'(cur_v), val_t'(3'b000));
        drain("t1", 50);

        // Multicast 0+2 with port 2 lagging: input must stall while port 2 owes a beat
        ready_pct = '{100, 100, 25};
        push_pkt(3'b101, 3, 3'b101);
        while (busy()) begin
            step();
            if (cur_v[2] && !cur_r[2])
                check_eq("t2_s_tready_blocked", val_t'(s_if.tready), val_t'(1'b0));
            if (checks > 5000) break;
        end
        drain("t2", 200);
        ready_pct = '{100, 100, 100};

        // Back-to-back single-word packets, no bubble
        push_pkt(3'b001, 1, 3'b001);
        push_pkt(3'b100, 1, 3'b100);
        a0 = n_accept;
        step_until_accepts(a0 + 1, "t3");
        step();
        check_eq("t3_first_on_0", val_t'(cur_v), val_t'(3'b001));
        step();
        check_eq("t3_second_on_2", val_t'(cur_v), val_t'(3'b100));
        drain("t3", 50);

        // Later-word destination bits are ignored
        push_pkt(3'b001, 3, 3'b100);
        drain("t4", 50);

        // Zero destination
        push_pkt(3'b000, 2, 3'b000);
        a0 = n_accept;
        while (n_accept < a0 + 2 && checks < 100000) begin
            step();
            if (s_if.tvalid) check_eq("t5_s_tready", val_t'(s_if.tready), val_t'(1'b1));
`ifdef NF10_OUTPUT_DISTRIBUTOR_DROP_EN
            check_eq("t5_no_tvalid", val_t'(cur_v), val_t'(3'b000));
`endif
        end
        step();
`ifdef NF10_OUTPUT_DISTRIBUTOR_DROP_EN
        check_eq("t5_no_tvalid_after", val_t'(cur_v), val_t'(3'b000));
`endif
        drain("t5", 50);

        // Reset mid-packet; word 3 then starts a new packet routed by its own tuser
        push_pkt(3'b001, 5, 3'b100);
        a0 = n_accept;
        step_until_accepts(a0 + 2, "t6");
        ready_pct = '{0, 0, 0};
        rst_req = 1;
        step();
        rst_req = 0;
        step();
        check_eq("t6_tvalid_after_reset", val_t'(cur_v), val_t'(3'b000));
        check_eq("t6_s_tready_after_reset", val_t'(s_if.tready), val_t'(1'b1));
        ready_pct = '{100, 100, 100};
        drain("t6", 50);

        // Randomised traffic in batches with varying gaps and backpressure
        for (int b = 0; b < 4; b++) begin
            gap_pct = $urandom_range(50);
            for (int k = 0; k < 3; k++) ready_pct[k] = $urandom_range(100, 20);
            for (int p = 0; p < 10; p++)
                push_pkt(3'($urandom_range(7)), $urandom_range(6, 1), 3'($urandom_range(7)));
            drain($sformatf("rand%0d", b), 5000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
